// File: rtl/difficulty_controller.sv
// Multi-level difficulty selector: steps a level in the select screen, optionally auto-escalates
// during play, and maps the level to registered scroll-speed and spawn-period codes.
module difficulty_controller #(
    parameter int LEVELS        = 4,
    parameter int LVL_W         = 2,
    parameter int SPEED_W       = 2,
    parameter int PER_W         = 8,
    parameter int BASE_PERIOD   = 128,
    parameter int DEFAULT_LEVEL = 1,
    parameter int ESC_BEATS     = 32,
    parameter int CNT_W         = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               game_start,
    input  logic               game_end,
    input  logic               auto_en,
    input  logic               beat_tick,
    output logic [LVL_W-1:0]   level,
    output logic [SPEED_W-1:0] speed_code,
    output logic [PER_W-1:0]   spawn_period,
    output logic               playing,
    output logic               level_up
);

    typedef enum logic {
        SELECT = 1'b0,
        PLAY   = 1'b1
    } state_t;

    localparam logic [LVL_W-1:0] MAX_LVL  = LVL_W'(LEVELS - 1);
    localparam logic [LVL_W-1:0] DEF_LVL  = LVL_W'(DEFAULT_LEVEL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ESC_BEATS - 1);

    function automatic logic [SPEED_W-1:0] map_speed(input logic [LVL_W-1:0] l);
        int v;
        int max_s;
        max_s = (1 << SPEED_W) - 1;
        v     = int'(l);
        if (v > max_s) v = max_s;
        return v[SPEED_W-1:0];
    endfunction

    function automatic logic [PER_W-1:0] map_period(input logic [LVL_W-1:0] l);
        int p;
        p = BASE_PERIOD >> int'(l);
        if (p < 1) p = 1;
        return p[PER_W-1:0];
    endfunction

    state_t             state, state_d;
    logic [LVL_W-1:0]   level_d;
    logic [LVL_W-1:0]   start_level, start_level_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               auto_q, auto_d;
    logic               btn_up_q, btn_down_q;
    logic               up_evt, down_evt;
    logic               level_up_d;
    logic [SPEED_W-1:0] speed_d;
    logic [PER_W-1:0]   period_d;
    logic               playing_d;

    assign up_evt   = btn_up & ~btn_up_q;
    assign down_evt = btn_down & ~btn_down_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SELECT;
            level        <= DEF_LVL;
            start_level  <= DEF_LVL;
            cnt          <= '0;
            auto_q       <= 1'b0;
            btn_up_q     <= 1'b0;
            btn_down_q   <= 1'b0;
            speed_code   <= map_speed(DEF_LVL);
            spawn_period <= map_period(DEF_LVL);
            playing      <= 1'b0;
            level_up     <= 1'b0;
        end else begin
            state        <= state_d;
            level        <= level_d;
            start_level  <= start_level_d;
            cnt          <= cnt_d;
            auto_q       <= auto_d;
            btn_up_q     <= btn_up;
            btn_down_q   <= btn_down;
            speed_code   <= speed_d;
            spawn_period <= period_d;
            playing      <= playing_d;
            level_up     <= level_up_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state;
        level_d       = level;
        start_level_d = start_level;
        cnt_d         = cnt;
        auto_d        = auto_q;
        level_up_d    = 1'b0;
        unique case (state)
            SELECT: begin
                if (game_start) begin
                    state_d       = PLAY;
                    start_level_d = level;
                    auto_d        = auto_en;
                    cnt_d         = '0;
                end else if (up_evt && !down_evt) begin
                    if (level < MAX_LVL) level_d = level + 1'b1;
                end else if (down_evt && !up_evt) begin
                    if (level != '0) level_d = level - 1'b1;
                end
            end
            PLAY: begin
                // game_end wins over a coincident beat so the restore is never followed by a stray step
                if (game_end) begin
                    state_d = SELECT;
                    level_d = start_level;
                    cnt_d   = '0;
                end else if (!auto_q) begin
                    cnt_d = '0;
                end else if (beat_tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_d = '0;
                        if (level < MAX_LVL) begin
                            level_d    = level + 1'b1;
                            level_up_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            default: state_d = SELECT;
        endcase
    end

    // Codes are derived from the next level so they register on the same edge as level itself.
    always_comb begin
        speed_d   = map_speed(level_d);
        period_d  = map_period(level_d);
        playing_d = (state_d == PLAY);
    end

endmodule

// File: doc/difficulty_controller.md
Name: difficulty_controller

Overview:
Parametrised successor to the single-bit difficulty converter. It holds a multi-level difficulty selection and converts it into registered scroll-speed and note-spawn-period codes for the arrow generator and scroller. Difficulty is stepped with menu buttons while in the select screen and locked during play. An optional auto-escalation mode raises the level every ESC_BEATS beats, and the chosen level is restored when the song ends.

Parameters:
LEVELS, 4, number of difficulty levels (2..2**LVL_W)
LVL_W, 2, width of level index
SPEED_W, 2, width of speed code
PER_W, 8, width of spawn period
BASE_PERIOD, 128, spawn period at level 0, in beats/ticks
DEFAULT_LEVEL, 1, level after reset
ESC_BEATS, 32, beats per auto-escalation step (>=1)
CNT_W, 6, beat counter width (2**CNT_W >= ESC_BEATS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
btn_up  in  1  level-up button, synchronised/debounced level
btn_down  in  1  level-down button, synchronised/debounced level
game_start  in  1  one-cycle pulse: song begins
game_end  in  1  one-cycle pulse: song over
auto_en  in  1  auto-escalation enable, sampled at game_start
beat_tick  in  1  one-cycle pulse per beat
level  out  LVL_W  current difficulty index
speed_code  out  SPEED_W  scroller speed code, higher = faster
spawn_period  out  PER_W  beats between spawned notes
playing  out  1  high in PLAY state
level_up  out  1  one-cycle pulse on an auto-escalation step

Behaviour:
- Reset, async, any time including mid-song:
  - state=SELECT, level=DEFAULT_LEVEL, start_level=DEFAULT_LEVEL.
  - Beat counter=0, auto latch=0, button history regs=0.
  - speed_code and spawn_period take their mapped values for DEFAULT_LEVEL; playing=0, level_up=0.
- All outputs are registered. A level change on edge n shows on level, speed_code and spawn_period together after edge n. They are never skewed by a cycle.
- Mapping (f(L)):
  - speed_code = min(L, 2**SPEED_W-1).
  - spawn_period = BASE_PERIOD >> L, floored at 1.
- Edge detect: up_evt = btn_up & ~btn_up_q; same for down_evt. History regs update every cycle in every state.
- SELECT state:
  - up_evt alone: level+1, saturating at LEVELS-1.
  - down_evt alone: level-1, saturating at 0.
  - up_evt and down_evt in the same cycle: no change.
  - A held button gives exactly one step.
  - beat_tick and game_end are ignored.
- SELECT->PLAY on game_start:
  - start_level<=level; auto latch<=auto_en; beat counter<=0; playing<=1 on the same edge.
  - Any button event in that cycle is ignored.
- PLAY state:
  - Buttons and game_start are ignored.
  - With the auto latch set, each beat_tick increments the counter.
  - On a beat_tick while counter==ESC_BEATS-1: counter<=0. If level<LEVELS-1, level+1 and level_up=1 for one cycle. At max level, no change and no pulse.
  - With the auto latch clear, the counter holds at 0.
- PLAY->SELECT on game_end:
  - level<=start_level (outputs remapped); playing<=0; counter<=0.
  - A beat_tick coinciding with game_end is discarded; no level_up.
- level_up is otherwise 0.

Test Plan:
- Reset then idle 5 cycles -> level=1, speed_code=1, spawn_period=64, playing=0.
- SELECT: btn_up held 10 cycles -> level=2 after one edge only. Three more press/release cycles -> saturates at 3, speed_code=3, spawn_period=16. Four down presses -> 0, spawn_period=128.
- SELECT: btn_up and btn_down rise in the same cycle -> level unchanged.
- auto_en=1, level=0, game_start, then 32 beat_ticks -> level_up pulse on the 32nd tick, level=1. After 96 ticks total level=3; further ticks give no pulse. Presses ignored throughout. game_end -> level=0, playing=0.
- auto_en=0, game_start, 100 beat_ticks -> level constant, no level_up.
- Assert rst mid-PLAY at level 3 -> immediately (async) level=1, playing=0. Counter cleared, verified by a subsequent game with 31 ticks giving no escalation.
